pueo_command_decoder: RTL and testbench
=======================================

// Module: pueo_command_decoder
// PURPOSE
//  Receive end of the 32-bit TURF->TURFIO/SURF command word. Slices each word at the command phase into
//  message events (PPS, run commands, firmware-update data/marks) and trigger words.
//  Triggers and FWU bytes are buffered in small FIFOs and presented as AXI4-Stream masters.
//  Run control is tracked in a STOPPED/RUNNING state machine. Protocol violations are counted.
// PARAMETERS
//  TRIG_FIFO_DEPTH  16  trigger FIFO entries (power of 2, >=4)
//  FWU_FIFO_DEPTH   16  FWU byte FIFO entries (power of 2, >=4)
//  CNT_BITS         16  width of saturating error/drop counters
// PORTS
//  sysclk_i          in   1   command clock; the only clock
//  sysclk_rstn_i     in   1   asynchronous, active-low reset
//  sysclk_phase_i    in   1   high one cycle per command word; command_i is valid in that cycle
//  command_i         in   32  command word
//  pps_o             out  1   1-cycle pulse: PPS bit seen
//  runsync_o         out  1   1-cycle pulse: runcmd==1
//  runrst_o          out  1   1-cycle pulse: runcmd==2
//  runstop_o         out  1   1-cycle pulse: runcmd==3
//  running_o         out  1   run FSM in RUNNING
//  m_trig_tdata      out  15  trigger word
//  m_trig_tvalid     out  1   trigger available
//  m_trig_tready     in   1   trigger consumer ready
//  m_fwu_tdata       out  8   FWU data byte
//  m_fwu_tvalid      out  1   FWU byte available
//  m_fwu_tready      in   1   FWU consumer ready
//  fwu_mark_o        out  1   1-cycle pulse: FWU mark received
//  fwu_mark_buf_o    out  1   buffer index carried with the mark (valid with fwu_mark_o)
//  trig_drop_cnt_o   out  CNT_BITS  triggers dropped (full FIFO or not RUNNING), saturating
//  fwu_drop_cnt_o    out  CNT_BITS  FWU bytes dropped (full FIFO), saturating
//  proto_err_cnt_o   out  CNT_BITS  malformed words, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; FIFOs empty; counters 0; run FSM STOPPED. The FSM resets mid-word without
//    side effects, and an in-flight word is discarded.
//  - Words are decoded only when sysclk_phase_i=1. All other cycles are ignored.
//  - Field map: [31]=idle, [30]=pps, [29:28]=rsvd, [27:26]=runcmd, [25:24]=m1type,
//    [23:16]=m1data, [15]=trig valid, [14:0]=trig data.
//  - Event pulses (pps/run*/fwu_mark) assert exactly 1 cycle, registered 1 cycle after the phase cycle.
//  - idle=1: message fields are ignored. If pps|runcmd|m1type are nonzero, proto_err_cnt_o += 1.
//  - idle=0: if pps=0, runcmd=0 and m1type=0 with m1data[1]=0, the message is empty. Count a proto
//    error; no events.
//  - rsvd!=0 or m1type in {1,2}: proto error. The other fields in the word are still decoded.
//  - m1type=3: push m1data into the FWU FIFO.
//  - m1type=0 with m1data[1]=1: fwu_mark_o=1 and fwu_mark_buf_o=m1data[0].
//  - The trigger field is independent of idle. If [15]=1 and running_o=1, push [14:0] into the trigger
//    FIFO. If [15]=1 and running_o=0, drop the trigger and count it.
//  - Run FSM, evaluated on the decoded word:
//    - STOPPED --runrst--> RUNNING
//    - RUNNING --runstop--> STOPPED
//    - runrst while RUNNING: stays RUNNING and flushes the trigger FIFO (run restart)
//    - runstop while STOPPED: no-op
//    - runsync: no state change
//  - Trigger gating uses running_o before the word's own runcmd is applied. A trigger in the same word
//    as runrst (while STOPPED) is dropped.
//  - FIFOs are first-word-fall-through AXI4S. tvalid=!empty; a pop happens on tvalid&tready.
//    - Push when full: drop the incoming entry and increment the drop counter.
//    - Simultaneous push and pop when full: the push is accepted; count stays full.
//    - Pointers wrap modulo depth; the full/empty flag uses an extra pointer bit.
//  - Flushing the trigger FIFO on restart overrides any same-cycle push and pop; the FIFO ends empty.
//  - Counters saturate at all-ones and never wrap. There is no clear other than reset.
//  - Latency: command phase cycle -> m_*_tvalid = 2 cycles (1 decode register + 1 FIFO write).
// STRUCTURE
//  - pueo_cmd_pkg: field bit-position localparams, runcmd enum
//    {RUN_NOOP=0, RUN_SYNC=1, RUN_RESET=2, RUN_STOP=3}, m1type enum {M1_NOP=0, M1_FWU=3},
//    run FSM state typedef {STOPPED, RUNNING}.
//  - Sub-module pueo_cmd_fifo (params WIDTH, DEPTH; push/full-drop, FWFT pop, sync flush), instantiated
//    twice (15-bit trigger, 8-bit FWU).
//  - Top level holds the decode register, run FSM and saturating counters.
// TESTING
//  1. Reset, then word 0x8000_0000 on each phase -> no pulses, FIFOs empty, all counters 0.
//  2. Word 0x0800_0000 (runrst) then 0x0000_8123 -> runrst_o for 1 cycle, running_o=1, then
//     m_trig_tdata=0x0123 with tvalid 2 cycles after the second phase.
//  3. Trigger 0x8005 while STOPPED -> no tvalid, trig_drop_cnt_o=1. Then runstop 0x0C00_0000 while
//     STOPPED -> runstop_o pulse, running_o stays 0.
//  4. 20 words 0x03AA_0000 with m_fwu_tready=0 -> 16 bytes 0xAA held, fwu_drop_cnt_o=4. Raise tready
//     -> 16 beats drain, then tvalid=0.
//  5. Word 0x0003_0000 -> fwu_mark_o=1, fwu_mark_buf_o=1. Word 0x8000_0001... is not a message ->
//     decode word 0x8100_0000 -> proto_err_cnt_o=1, no FWU push.
//  6. RUNNING with 3 queued triggers, then runrst -> FIFO empty the next cycle, running_o stays 1.
//     Deassert sysclk_rstn_i mid-stream -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/pueo_cmd_pkg.sv
// Shared definitions for the PUEO command-word decoder: field positions, run commands,
// message types and the run-control state.
package pueo_cmd_pkg;

  localparam int CMD_W          = 32;
  localparam int IDLE_BIT       = 31;
  localparam int PPS_BIT        = 30;
  localparam int RSVD_HI        = 29;
  localparam int RSVD_LO        = 28;
  localparam int RUNCMD_HI      = 27;
  localparam int RUNCMD_LO      = 26;
  localparam int M1TYPE_HI      = 25;
  localparam int M1TYPE_LO      = 24;
  localparam int M1DATA_HI      = 23;
  localparam int M1DATA_LO      = 16;
  localparam int TRIG_VALID_BIT = 15;
  localparam int TRIG_W         = 15;
  localparam int FWU_W          = 8;

  typedef enum logic [1:0] {
    RUN_NOOP  = 2'd0,
    RUN_SYNC  = 2'd1,
    RUN_RESET = 2'd2,
    RUN_STOP  = 2'd3
  } runcmd_e;

  typedef enum logic [1:0] {
    M1_NOP = 2'd0,
    M1_FWU = 2'd3
  } m1type_e;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  typedef struct packed {
    logic              idle;
    logic              pps;
    logic [1:0]        rsvd;
    logic [1:0]        runcmd;
    logic [1:0]        m1type;
    logic [FWU_W-1:0]  m1data;
    logic              trig_valid;
    logic [TRIG_W-1:0] trig_data;
  } cmd_word_t;

  // Everything one decoded word can cause, held for exactly one cycle.
  typedef struct packed {
    logic              pps;
    logic              runsync;
    logic              runrst;
    logic              runstop;
    logic              fwu_mark;
    logic              fwu_mark_buf;
    logic              fwu_push;
    logic [FWU_W-1:0]  fwu_data;
    logic              trig_push;
    logic              trig_drop;
    logic              trig_flush;
    logic [TRIG_W-1:0] trig_data;
    logic              proto_err;
  } dec_t;

  function automatic cmd_word_t unpack_cmd(input logic [CMD_W-1:0] w);
    cmd_word_t c;
    c.idle       = w[IDLE_BIT];
    c.pps        = w[PPS_BIT];
    c.rsvd       = w[RSVD_HI:RSVD_LO];
    c.runcmd     = w[RUNCMD_HI:RUNCMD_LO];
    c.m1type     = w[M1TYPE_HI:M1TYPE_LO];
    c.m1data     = w[M1DATA_HI:M1DATA_LO];
    c.trig_valid = w[TRIG_VALID_BIT];
    c.trig_data  = w[TRIG_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/pueo_cmd_if.sv
// AXI4-Stream outputs of the command decoder: trigger words and firmware-update bytes.
interface pueo_cmd_if;
  import pueo_cmd_pkg::*;

  logic [TRIG_W-1:0] m_trig_tdata;
  logic              m_trig_tvalid;
  logic              m_trig_tready;
  logic [FWU_W-1:0]  m_fwu_tdata;
  logic              m_fwu_tvalid;
  logic              m_fwu_tready;

  modport master (
    output m_trig_tdata, m_trig_tvalid, m_fwu_tdata, m_fwu_tvalid,
    input  m_trig_tready, m_fwu_tready
  );

  modport slave (
    input  m_trig_tdata, m_trig_tvalid, m_fwu_tdata, m_fwu_tvalid,
    output m_trig_tready, m_fwu_tready
  );
endinterface

// File: rtl/pueo_cmd_fifo.sv
// First-word-fall-through FIFO with drop-on-full push and a synchronous flush.
// Pointers carry one extra bit so full and empty are distinguishable.
module pueo_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             drop_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  input  logic             pop_ready_i
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic empty, full, pop, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && pop_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop && !flush_i;

  assign pop_valid_o = !empty;
  assign pop_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pueo_command_decoder.sv
// Receive side of the TURF command word: decodes message/trigger fields once per command
// phase, tracks run control, buffers triggers and FWU bytes, and counts errors/drops.
module pueo_command_decoder
  import pueo_cmd_pkg::*;
#(
  parameter int TRIG_FIFO_DEPTH = 16,
  parameter int FWU_FIFO_DEPTH  = 16,
  parameter int CNT_BITS        = 16
) (
  input  logic                sysclk_i,
  input  logic                sysclk_rstn_i,
  input  logic                sysclk_phase_i,
  input  logic [CMD_W-1:0]    command_i,
  output logic                pps_o,
  output logic                runsync_o,
  output logic                runrst_o,
  output logic                runstop_o,
  output logic                running_o,
  pueo_cmd_if.master          m_axis,
  output logic                fwu_mark_o,
  output logic                fwu_mark_buf_o,
  output logic [CNT_BITS-1:0] trig_drop_cnt_o,
  output logic [CNT_BITS-1:0] fwu_drop_cnt_o,
  output logic [CNT_BITS-1:0] proto_err_cnt_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  cmd_word_t  w;
  logic       msg_empty;
  logic       running;
  dec_t       dec_d, dec_q;
  run_state_e state_d, state_q;

  logic [CNT_BITS-1:0] trig_drop_cnt_d, trig_drop_cnt_q;
  logic [CNT_BITS-1:0] fwu_drop_cnt_d,  fwu_drop_cnt_q;
  logic [CNT_BITS-1:0] proto_err_cnt_d, proto_err_cnt_q;

  logic trig_fifo_drop, fwu_fifo_drop;

  assign w       = unpack_cmd(command_i);
  assign running = (state_q == RUNNING);

  // A non-idle word whose bit 17 (mark request) is clear and with no other message is empty.
  assign msg_empty = !w.pps && (w.runcmd == RUN_NOOP) && (w.m1type == M1_NOP) && !w.m1data[1];

  // ---------------- decode ----------------
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    dec_d = '0;
    if (sysclk_phase_i) begin
      if (w.idle) begin
        dec_d.proto_err = w.pps || (|w.runcmd) || (|w.m1type);
      end else begin
        dec_d.pps          = w.pps;
        dec_d.runsync      = (w.runcmd == RUN_SYNC);
        dec_d.runrst       = (w.runcmd == RUN_RESET);
        dec_d.runstop      = (w.runcmd == RUN_STOP);
        dec_d.fwu_push     = (w.m1type == M1_FWU);
        dec_d.fwu_data     = w.m1data;
        dec_d.fwu_mark     = (w.m1type == M1_NOP) && w.m1data[1];
        dec_d.fwu_mark_buf = (w.m1type == M1_NOP) && w.m1data[1] && w.m1data[0];
        dec_d.trig_flush   = (w.runcmd == RUN_RESET) && running;
        dec_d.proto_err    = (|w.rsvd) || (w.m1type == 2'd1) || (w.m1type == 2'd2) || msg_empty;
      end
      // Trigger gating sees the run state from before this word's own run command.
      dec_d.trig_push = w.trig_valid && running;
      dec_d.trig_drop = w.trig_valid && !running;
      dec_d.trig_data = w.trig_data;
    end
  end

  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) dec_q <= '0;
    else                dec_q <= dec_d;
  end

  // ---------------- run FSM ----------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) state_q <= STOPPED;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sysclk_phase_i && !w.idle) begin
      case (w.runcmd)
        RUN_RESET: state_d = RUNNING;
        RUN_STOP:  state_d = STOPPED;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    running_o = (state_q == RUNNING);
  end

  // ---------------- event outputs ----------------
  assign pps_o          = dec_q.pps;
  assign runsync_o      = dec_q.runsync;
  assign runrst_o       = dec_q.runrst;
  assign runstop_o      = dec_q.runstop;
  assign fwu_mark_o     = dec_q.fwu_mark;
  assign fwu_mark_buf_o = dec_q.fwu_mark_buf;

  // ---------------- FIFOs ----------------
  logic [TRIG_W-1:0] trig_tdata;
  logic              trig_tvalid;
  logic [FWU_W-1:0]  fwu_tdata;
  logic              fwu_tvalid;

  pueo_cmd_fifo #(.WIDTH(TRIG_W), .DEPTH(TRIG_FIFO_DEPTH)) u_trig_fifo (
    .clk         (sysclk_i),
    .rst_n       (sysclk_rstn_i),
    .flush_i     (dec_q.trig_flush),
    .push_i      (dec_q.trig_push),
    .push_data_i (dec_q.trig_data),
    .drop_o      (trig_fifo_drop),
    .pop_data_o  (trig_tdata),
    .pop_valid_o (trig_tvalid),
    .pop_ready_i (m_axis.m_trig_tready)
  );

  pueo_cmd_fifo #(.WIDTH(FWU_W), .DEPTH(FWU_FIFO_DEPTH)) u_fwu_fifo (
    .clk         (sysclk_i),
    .rst_n       (sysclk_rstn_i),
    .flush_i     (1'b0),
    .push_i      (dec_q.fwu_push),
    .push_data_i (dec_q.fwu_data),
    .drop_o      (fwu_fifo_drop),
    .pop_data_o  (fwu_tdata),
    .pop_valid_o (fwu_tvalid),
    .pop_ready_i (m_axis.m_fwu_tready)
  );

  assign m_axis.m_trig_tdata  = trig_tdata;
  assign m_axis.m_trig_tvalid = trig_tvalid;
  assign m_axis.m_fwu_tdata   = fwu_tdata;
  assign m_axis.m_fwu_tvalid  = fwu_tvalid;

  // ---------------- saturating counters ----------------
  always_comb begin
    trig_drop_cnt_d = trig_drop_cnt_q;
    fwu_drop_cnt_d  = fwu_drop_cnt_q;
    proto_err_cnt_d = proto_err_cnt_q;
    if ((dec_q.trig_drop || trig_fifo_drop) && trig_drop_cnt_q != CNT_MAX)
      trig_drop_cnt_d = trig_drop_cnt_q + CNT_ONE;
    if (fwu_fifo_drop && fwu_drop_cnt_q != CNT_MAX)
      fwu_drop_cnt_d = fwu_drop_cnt_q + CNT_ONE;
    if (dec_q.proto_err && proto_err_cnt_q != CNT_MAX)
      proto_err_cnt_d = proto_err_cnt_q + CNT_ONE;
  end

  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      trig_drop_cnt_q <= '0;
      fwu_drop_cnt_q  <= '0;
      proto_err_cnt_q <= '0;
    end else begin
      trig_drop_cnt_q <= trig_drop_cnt_d;
      fwu_drop_cnt_q  <= fwu_drop_cnt_d;
      proto_err_cnt_q <= proto_err_cnt_d;
    end
  end

  assign trig_drop_cnt_o = trig_drop_cnt_q;
  assign fwu_drop_cnt_o  = fwu_drop_cnt_q;
  assign proto_err_cnt_o = proto_err_cnt_q;

endmodule

// File: tb/tb_pueo_command_decoder.sv
// Directed bench for pueo_command_decoder: a vector table for message decode and run
// control, plus hand sequences for FIFO latency, full/drop, flush, saturation and reset.
module tb_pueo_command_decoder;
  import pueo_cmd_pkg::*;

  localparam int CNT_BITS = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                phase;
  logic [31:0]         cmd;
  logic                pps_o, runsync_o, runrst_o, runstop_o, running_o;
  logic                fwu_mark_o, fwu_mark_buf_o;
  logic [CNT_BITS-1:0] trig_drop_cnt_o, fwu_drop_cnt_o, proto_err_cnt_o;

  pueo_cmd_if axis ();

  pueo_command_decoder #(
    .TRIG_FIFO_DEPTH (16),
    .FWU_FIFO_DEPTH  (16),
    .CNT_BITS        (CNT_BITS)
  ) dut (
    .sysclk_i        (clk),
    .sysclk_rstn_i   (rst_n),
    .sysclk_phase_i  (phase),
    .command_i       (cmd),
    .pps_o           (pps_o),
    .runsync_o       (runsync_o),
    .runrst_o        (runrst_o),
    .runstop_o       (runstop_o),
    .running_o       (running_o),
    .m_axis          (axis),
    .fwu_mark_o      (fwu_mark_o),
    .fwu_mark_buf_o  (fwu_mark_buf_o),
    .trig_drop_cnt_o (trig_drop_cnt_o),
    .fwu_drop_cnt_o  (fwu_drop_cnt_o),
    .proto_err_cnt_o (proto_err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic [5:0]  pulses;   // {pps, runsync, runrst, runstop, fwu_mark, fwu_mark_buf}
    logic        running;
    int          perr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pulses();
    return {pps_o, runsync_o, runrst_o, runstop_o, fwu_mark_o, fwu_mark_buf_o};
  endfunction

  // Returns on the falling edge after the capturing rising edge.
  task automatic send(input logic [31:0] w);
    @(negedge clk);
    phase = 1'b1;
    cmd   = w;
    @(negedge clk);
    phase = 1'b0;
    cmd   = 32'h0;
  endtask

  // Raise tready for a bounded window and compare each beat with exp_q.
  task automatic drain(input bit is_fwu, input string name);
    int   beats = 0;
    int   n_exp = exp_q.size();
    logic v;
    logic [14:0] d, e;
    if (is_fwu) axis.m_fwu_tready = 1'b1;
    else        axis.m_trig_tready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      v = is_fwu ? axis.m_fwu_tvalid : axis.m_trig_tvalid;
      d = is_fwu ? {7'h0, axis.m_fwu_tdata} : axis.m_trig_tdata;
      if (v) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7fff;
        check({name, "_beat"}, {17'h0, d}, {17'h0, e});
        beats++;
      end
      @(negedge clk);
    end
    axis.m_fwu_tready  = 1'b0;
    axis.m_trig_tready = 1'b0;
    check({name, "_beats"}, beats, n_exp);
    check({name, "_empty"}, is_fwu ? axis.m_fwu_tvalid : axis.m_trig_tvalid, 0);
  endtask

  initial begin
    vecs[0]  = '{32'h8000_0000, 6'b000000, 1'b0, 0};
    vecs[1]  = '{32'hC000_0000, 6'b000000, 1'b0, 1};
    vecs[2]  = '{32'h4000_0000, 6'b100000, 1'b0, 1};
    vecs[3]  = '{32'h0400_0000, 6'b010000, 1'b0, 1};
    vecs[4]  = '{32'h0C00_0000, 6'b000100, 1'b0, 1};
    vecs[5]  = '{32'h0800_0000, 6'b001000, 1'b1, 1};
    vecs[6]  = '{32'h0800_0000, 6'b001000, 1'b1, 1};
    vecs[7]  = '{32'h0000_0000, 6'b000000, 1'b1, 2};
    vecs[8]  = '{32'h1000_0000, 6'b000000, 1'b1, 3};
    vecs[9]  = '{32'h5002_0000, 6'b100010, 1'b1, 4};
    vecs[10] = '{32'h0103_0000, 6'b000000, 1'b1, 5};
    vecs[11] = '{32'h0003_0000, 6'b000011, 1'b1, 5};
    vecs[12] = '{32'h4C00_0000, 6'b100100, 1'b0, 5};
    vecs[13] = '{32'h8800_0000, 6'b000000, 1'b0, 6};

    rst_n = 1'b0;
    phase = 1'b0;
    cmd   = 32'h0;
    axis.m_trig_tready = 1'b0;
    axis.m_fwu_tready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'h0, pulses()}, 0);
    check("reset_running", running_o, 0);
    check("reset_tvalid", {axis.m_trig_tvalid, axis.m_fwu_tvalid}, 0);
    check("reset_counters", {trig_drop_cnt_o, fwu_drop_cnt_o, proto_err_cnt_o}, 0);
    rst_n = 1'b1;

    // Message decode and run control table.
    foreach (vecs[i]) begin
      send(vecs[i].word);
      check($sformatf("vec%0d_pulses", i), {26'h0, pulses()}, {26'h0, vecs[i].pulses});
      check($sformatf("vec%0d_running", i), running_o, vecs[i].running);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), {26'h0, pulses()}, 0);
      check($sformatf("vec%0d_perr", i), proto_err_cnt_o, vecs[i].perr);
    end

    // Trigger while STOPPED is dropped.
    send(32'h8000_8005);
    @(negedge clk);
    check("stopped_trig_tvalid", axis.m_trig_tvalid, 0);
    check("stopped_trig_drop", trig_drop_cnt_o, 1);

    // Start a run; trigger appears two cycles after its phase.
    send(32'h0800_0000);
    check("run_start", running_o, 1);
    send(32'h8000_8123);
    check("trig_lat1_tvalid", axis.m_trig_tvalid, 0);
    @(negedge clk);
    check("trig_lat2_tvalid", axis.m_trig_tvalid, 1);
    check("trig_lat2_tdata", axis.m_trig_tdata, 15'h0123);

    // Three queued triggers, then run restart flushes them.
    send(32'h8000_8001);
    send(32'h8000_8002);
    send(32'h0800_0000);
    check("restart_pre_flush", axis.m_trig_tvalid, 1);
    @(negedge clk);
    check("restart_flushed", axis.m_trig_tvalid, 0);
    check("restart_running", running_o, 1);
    check("restart_drop", trig_drop_cnt_o, 1);

    // Trigger in the same word as runrst while STOPPED is dropped.
    send(32'h0C00_0000);
    check("stop_running", running_o, 0);
    send(32'h0800_8077);
    check("sameword_running", running_o, 1);
    @(negedge clk);
    check("sameword_tvalid", axis.m_trig_tvalid, 0);
    check("sameword_drop", trig_drop_cnt_o, 2);

    // Trigger FIFO overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) send(32'h8000_8000 | i);
    @(negedge clk);
    check("trig_full_drop", trig_drop_cnt_o, 3);
    for (int i = 0; i < 16; i++) exp_q.push_back(15'(i));
    drain(1'b0, "trig_drain");

    // FWU overflow: 20 bytes into 16 entries.
    for (int i = 0; i < 20; i++) send(32'h03AA_0000);
    @(negedge clk);
    check("fwu_full_drop", fwu_drop_cnt_o, 4);
    for (int i = 0; i < 16; i++) exp_q.push_back(15'h00AA);
    drain(1'b1, "fwu_drain");

    // Push while full with a same-cycle pop is accepted.
    for (int i = 0; i < 16; i++) send(32'h0300_0000 | (i << 16));
    send(32'h0355_0000);
    axis.m_fwu_tready = 1'b1;
    @(negedge clk);
    axis.m_fwu_tready = 1'b0;
    check("fwu_pushpop_drop", fwu_drop_cnt_o, 4);
    for (int i = 1; i < 16; i++) exp_q.push_back(15'(i));
    exp_q.push_back(15'h0055);
    drain(1'b1, "fwu_pushpop");

    // Idle word with m1type set is a protocol error, not an FWU push.
    send(32'h8100_0000);
    @(negedge clk);
    check("idle_m1_perr", proto_err_cnt_o, 7);
    check("idle_m1_no_push", axis.m_fwu_tvalid, 0);

    // Protocol error counter saturates at all-ones.
    for (int i = 0; i < 9; i++) send(32'hC000_0000);
    @(negedge clk);
    check("perr_saturate", proto_err_cnt_o, 15);

    // Asynchronous reset in the middle of a command phase.
    send(32'h8000_8042);
    @(negedge clk);
    check("pre_reset_tvalid", axis.m_trig_tvalid, 1);
    @(negedge clk);
    phase = 1'b1;
    cmd   = 32'h4800_0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {23'h0, pulses(), running_o, axis.m_trig_tvalid, axis.m_fwu_tvalid}, 0);
    check("async_reset_counters", {trig_drop_cnt_o, fwu_drop_cnt_o, proto_err_cnt_o}, 0);
    @(negedge clk);
    phase = 1'b0;
    cmd   = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_quiet", {25'h0, pulses(), running_o}, 0);
    check("post_reset_tvalid", axis.m_trig_tvalid, 0);
    send(32'h0800_0000);
    check("post_reset_runrst", {25'h0, pulses(), running_o}, 7'b0010001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
